vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Downstream consumer of the VGA horizontal pixel counter (10-bit `HADDR` 0..799, `HTC` high during the `HADDR==0` cycle that follows each 799→0 rollover).

- Maintains the vertical line counter (0..524).
- Decodes both counters into registered sync, data-enable and pixel-coordinate outputs for the 640x480@60 Hz raster.
- Feeds the video DAC pins and the framebuffer read-address logic.

## Interface

Parameters:
- `H_VIS`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch; `H_VIS+H_FP+H_SYNC+H_BP` must equal 800, the upstream counter period
- `V_VIS`, 480, visible lines
- `V_FP`, 10, vertical front porch
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch; total 525
- `HS_POL`, 0, HSYNC active level
- `VS_POL`, 0, VSYNC active level

Ports:
- `CLK`  in  1  pixel clock, shared with the horizontal counter
- `RST`  in  1  reset, synchronous, active-high; asserted in the same cycles as the horizontal counter's reset
- `HADDR`  in  10  horizontal position from the upstream counter
- `HTC`  in  1  line-advance pulse from the upstream counter
- `HSYNC`  out  1  horizontal sync, level per `HS_POL`
- `VSYNC`  out  1  vertical sync, level per `VS_POL`
- `DE`  out  1  data enable, high in the visible region
- `PIX_X`  out  10  visible column; 0 when `DE=0`
- `PIX_Y`  out  9  visible row; 0 when `DE=0`
- `VLINE`  out  10  current line 0..524, aligned with the other outputs
- `FSTART`  out  1  one-cycle pulse aligned with pixel (0,0)
- `LSTART`  out  1  one-cycle pulse aligned with column 0 of every line 0..524

## Operation

- Internal vertical counter `V`, reset value 524.
- On `HTC=1`: `V <= (V==524) ? 0 : V+1`. Otherwise `V` holds.
- Effective line `L = HTC ? next(V) : V`, computed combinationally. Every decode for the current `HADDR` uses `L`, so `HADDR==0` decodes against the new line, not the old one.
- Horizontal decode, with `h = HADDR`:
  - visible: `h < H_VIS`
  - sync: `H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC`, i.e. 656..751 at defaults
- Vertical decode, with `L`:
  - visible: `L < V_VIS`
  - sync: `V_VIS+V_FP <= L < V_VIS+V_FP+V_SYNC`, i.e. 490..491 at defaults
- Output decodes:
  - `DE` = h-visible AND v-visible
  - `PIX_X = DE ? h : 0`
  - `PIX_Y = DE ? L[8:0] : 0`
  - `LSTART = HTC`
  - `FSTART = HTC AND (next(V)==0)`
- `HSYNC` is asserted across the whole h-sync window on every line, including blank lines. `VSYNC` is asserted for the whole of lines 490..491, all 800 cycles of each.
- Width rules:
  - `V` is 10 bits; the comparison against 524 is exact, with no modulo tricks.
  - `PIX_Y` is truncated to 9 bits only inside the visible region, where `L < 480` and the value fits.
- Robustness:
  - `HTC` asserted while `HADDR != 0` is still honoured as a line advance; the counter is not re-derived from `HADDR`.
  - `HADDR` > 799 decodes as blank, non-sync.
- `RST` dominates `HTC` in the same cycle.

## Timing

- Every output is a register. Latency is exactly 1 cycle from `HADDR`/`HTC` to the outputs.
  - Example: `HADDR=656` in cycle t gives `HSYNC` active in cycle t+1.
- Reset values, held for every `RST` cycle and the first cycle after:

| Output | Reset value |
|---|---|
| `V`, `VLINE` | 524 |
| `HSYNC` | inactive (1 at default polarity) |
| `VSYNC` | inactive (1 at default polarity) |
| `DE` | 0 |
| `PIX_X`, `PIX_Y` | 0 |
| `FSTART`, `LSTART` | 0 |

- After `RST` deasserts:
  - The upstream counter sits at 799, then 0 with `HTC=1`.
  - `V` becomes 0.
  - `FSTART`, `LSTART` and `DE` go high 1 cycle after that `HADDR=0` cycle, with `PIX_X=0`, `PIX_Y=0`.
- Frame period is 420000 cycles; `FSTART` pulses exactly once per frame.
- Reset mid-frame: all outputs take their reset values on the next edge. No sync pulse is stretched or resumed after reset.

## Test plan

- **Reset values:** hold `RST` for 3 cycles while driving arbitrary `HADDR`/`HTC` → every output equals its reset value in every reset cycle and the following cycle; `VLINE=524`.
- **First pixel:** release `RST` with the reference upstream counter attached → `FSTART=1`, `LSTART=1`, `DE=1`, `PIX_X=0`, `PIX_Y=0` exactly 2 cycles after the first post-reset edge. `FSTART` is low for the next 419999 cycles.
- **HSYNC window:** on line 10 → `HSYNC=0` in exactly the 96 cycles following `HADDR=656..751`. `DE` is high for 640 cycles and falls the cycle after `HADDR=640`.
- **VSYNC window:** run a full frame → `VSYNC=0` for exactly 1600 consecutive cycles, covering `VLINE` 490 and 491. `DE` stays 0 for all of lines 480..524. Frame total is 307200 `DE` cycles.
- **Wrap and line-0 alignment:** at `HADDR=0` with `HTC=1` and `V=524` → `VLINE=0`, `FSTART=1` next cycle. Check there is no cycle where `VLINE=524` coincides with `PIX_X=0`, `DE=1`.
- **Reset mid-frame:** assert `RST` for 1 cycle at line 300, `HADDR=320`, then release → output values at reset, then the frame restarts from (0,0) after 2 cycles. Also assert `RST` together with `HTC=1` → `V` stays 524, `RST` wins.

Source files
------------

// File: rtl/vga_sync_gen.sv
// Vertical line counter and registered 640x480@60 raster decode, driven by the
// upstream horizontal pixel counter (HADDR/HTC). All outputs lag their inputs by one cycle.
module vga_sync_gen #(
    parameter int   H_VIS  = 640,
    parameter int   H_FP   = 16,
    parameter int   H_SYNC = 96,
    parameter int   H_BP   = 48,
    parameter int   V_VIS  = 480,
    parameter int   V_FP   = 10,
    parameter int   V_SYNC = 2,
    parameter int   V_BP   = 33,
    parameter logic HS_POL = 1'b0,
    parameter logic VS_POL = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [9:0] HADDR,
    input  logic       HTC,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       DE,
    output logic [9:0] PIX_X,
    output logic [8:0] PIX_Y,
    output logic [9:0] VLINE,
    output logic       FSTART,
    output logic       LSTART
);

    localparam logic [9:0] H_VIS_W   = 10'(H_VIS);
    localparam logic [9:0] H_SYNC_LO = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SYNC_HI = 10'(H_VIS + H_FP + H_SYNC);
    localparam int         H_TOTAL   = H_VIS + H_FP + H_SYNC + H_BP;
    localparam logic [9:0] V_VIS_W   = 10'(V_VIS);
    localparam logic [9:0] V_SYNC_LO = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SYNC_HI = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST    = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

    logic [9:0] r_v;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_de;
    logic [9:0] r_pix_x;
    logic [8:0] r_pix_y;
    logic [9:0] r_vline;
    logic       r_fstart;
    logic       r_lstart;

    logic [9:0] w_v_next;
    logic [9:0] w_line;
    logic       w_h_vis;
    logic       w_h_sync;
    logic       w_v_vis;
    logic       w_v_sync;
    logic       w_de;

    // Line-advance arithmetic and decode of the effective line; HADDR==0 with HTC
    // must see the new line, so the decode uses the post-increment value.
    always_comb begin
        w_v_next = 10'd0;
        if (r_v == V_LAST) begin
            w_v_next = 10'd0;
        end else begin
            w_v_next = r_v + 10'd1;
        end
        w_line   = HTC ? w_v_next : r_v;
        w_h_vis  = (HADDR < H_VIS_W);
        w_h_sync = ({22'd0, HADDR} < 32'(H_TOTAL)) && (HADDR >= H_SYNC_LO) && (HADDR < H_SYNC_HI);
        w_v_vis  = (w_line < V_VIS_W);
        w_v_sync = (w_line >= V_SYNC_LO) && (w_line < V_SYNC_HI);
        w_de     = w_h_vis && w_v_vis;
    end

    // Vertical counter and registered outputs; reset overrides a coincident HTC.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_v      <= V_LAST;
            r_hsync  <= ~HS_POL;
            r_vsync  <= ~VS_POL;
            r_de     <= 1'b0;
            r_pix_x  <= 10'd0;
            r_pix_y  <= 9'd0;
            r_vline  <= V_LAST;
            r_fstart <= 1'b0;
            r_lstart <= 1'b0;
        end else begin
            r_v      <= w_line;
            r_hsync  <= w_h_sync ? HS_POL : ~HS_POL;
            r_vsync  <= w_v_sync ? VS_POL : ~VS_POL;
            r_de     <= w_de;
            r_pix_x  <= w_de ? HADDR : 10'd0;
            r_pix_y  <= w_de ? w_line[8:0] : 9'd0;
            r_vline  <= w_line;
            r_fstart <= HTC && (w_v_next == 10'd0);
            r_lstart <= HTC;
        end
    end

    assign HSYNC  = r_hsync;
    assign VSYNC  = r_vsync;
    assign DE     = r_de;
    assign PIX_X  = r_pix_x;
    assign PIX_Y  = r_pix_y;
    assign VLINE  = r_vline;
    assign FSTART = r_fstart;
    assign LSTART = r_lstart;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: the horizontal counter is emulated by driving
// HADDR/HTC directly, with HTC pulses at a blank HADDR used to skip lines quickly.
module tb_vga_sync_gen;

    logic       CLK;
    logic       RST;
    logic [9:0] HADDR;
    logic       HTC;
    logic       HSYNC, VSYNC, DE, FSTART, LSTART;
    logic [9:0] PIX_X, VLINE;
    logic [8:0] PIX_Y;

    int n_checks;
    int n_fail;

    logic [33:0] obs;
    logic [33:0] exp_v;
    logic [33:0] rst_vec;
    logic [33:0] first_vec;

    vga_sync_gen dut (
        .CLK    (CLK),
        .RST    (RST),
        .HADDR  (HADDR),
        .HTC    (HTC),
        .HSYNC  (HSYNC),
        .VSYNC  (VSYNC),
        .DE     (DE),
        .PIX_X  (PIX_X),
        .PIX_Y  (PIX_Y),
        .VLINE  (VLINE),
        .FSTART (FSTART),
        .LSTART (LSTART)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign obs = {HSYNC, VSYNC, DE, PIX_X, PIX_Y, VLINE, FSTART, LSTART};

    // Apply one input vector, then sample the outputs it produced just after the edge.
    task automatic drive(input logic [9:0] h, input logic t);
        HADDR = h;
        HTC   = t;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(10'(i * 300 + 56), 1'b1);
            n_checks++;
            if (obs !== rst_vec) begin
                n_fail++;
                $display("FAIL reset_cycle%0d: got %h expected %h", i, obs, rst_vec);
            end
        end
        RST = 1'b0;
        drive(10'd799, 1'b0);
        n_checks++;
        if (obs !== rst_vec) begin
            n_fail++;
            $display("FAIL reset_after: got %h expected %h", obs, rst_vec);
        end
    endtask

    task automatic test_first_pixel();
        drive(10'd0, 1'b1);
        n_checks++;
        if (obs !== first_vec) begin
            n_fail++;
            $display("FAIL first_pixel: got %h expected %h", obs, first_vec);
        end
        for (int h = 1; h < 800; h++) begin
            drive(10'(h), 1'b0);
            n_checks++;
            if ({FSTART, LSTART, VLINE} !== {1'b0, 1'b0, 10'd0}) begin
                n_fail++;
                $display("FAIL line0_pulses h=%0d: got %b%b/%0d expected 00/0", h, FSTART, LSTART, VLINE);
            end
        end
    endtask

    task automatic test_hsync();
        int hs_low;
        int de_cnt;
        logic hs, de;
        for (int k = 1; k <= 9; k++) drive(10'd800, 1'b1);
        n_checks++;
        if ({HSYNC, DE, VLINE, LSTART, FSTART} !== {1'b1, 1'b0, 10'd9, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL htc_midline: got %b %b %0d %b %b expected 1 0 9 1 0", HSYNC, DE, VLINE, LSTART, FSTART);
        end
        hs_low = 0;
        de_cnt = 0;
        for (int h = 0; h < 800; h++) begin
            drive(10'(h), h == 0);
            hs = !(h >= 656 && h <= 751);
            de = (h < 640);
            exp_v = {hs, 1'b1, de, de ? 10'(h) : 10'd0, de ? 9'd10 : 9'd0, 10'd10, 1'b0, h == 0};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL line10 h=%0d: got %h expected %h", h, obs, exp_v);
            end
            if (!HSYNC) hs_low++;
            if (DE) de_cnt++;
        end
        n_checks++;
        if (hs_low !== 96) begin
            n_fail++;
            $display("FAIL hsync_width: got %0d expected 96", hs_low);
        end
        n_checks++;
        if (de_cnt !== 640) begin
            n_fail++;
            $display("FAIL de_width: got %0d expected 640", de_cnt);
        end
        drive(10'd1000, 1'b0);
        exp_v = {1'b1, 1'b1, 1'b0, 10'd0, 9'd0, 10'd10, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL haddr_out_of_range: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_vsync();
        int vs_low;
        int run;
        int max_run;
        int de_cnt;
        logic hs, vs, de;
        for (int k = 11; k <= 478; k++) drive(10'd800, 1'b1);
        vs_low  = 0;
        run     = 0;
        max_run = 0;
        de_cnt  = 0;
        for (int l = 479; l <= 524; l++) begin
            for (int h = 0; h < 800; h++) begin
                drive(10'(h), h == 0);
                hs = !(h >= 656 && h <= 751);
                vs = !(l == 490 || l == 491);
                de = (h < 640) && (l < 480);
                exp_v = {hs, vs, de, de ? 10'(h) : 10'd0, de ? 9'(l) : 9'd0, 10'(l), 1'b0, h == 0};
                n_checks++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL vframe l=%0d h=%0d: got %h expected %h", l, h, obs, exp_v);
                end
                if (!VSYNC) begin
                    vs_low++;
                    run++;
                    if (run > max_run) max_run = run;
                end else begin
                    run = 0;
                end
                if (DE) de_cnt++;
            end
        end
        n_checks++;
        if (vs_low !== 1600 || max_run !== 1600) begin
            n_fail++;
            $display("FAIL vsync_width: got %0d total %0d run expected 1600", vs_low, max_run);
        end
        n_checks++;
        if (de_cnt !== 640) begin
            n_fail++;
            $display("FAIL de_lines_479_524: got %0d expected 640", de_cnt);
        end
    endtask

    task automatic test_wrap();
        drive(10'd0, 1'b1);
        n_checks++;
        if (obs !== first_vec) begin
            n_fail++;
            $display("FAIL wrap_to_line0: got %h expected %h", obs, first_vec);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 1; k <= 300; k++) drive(10'd800, 1'b1);
        drive(10'd320, 1'b0);
        exp_v = {1'b1, 1'b1, 1'b1, 10'd320, 9'd300, 10'd300, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL line300_px320: got %h expected %h", obs, exp_v);
        end
        drive(10'd700, 1'b0);
        exp_v = {1'b0, 1'b1, 1'b0, 10'd0, 9'd0, 10'd300, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL line300_hsync: got %h expected %h", obs, exp_v);
        end
        RST = 1'b1;
        drive(10'd701, 1'b0);
        n_checks++;
        if (obs !== rst_vec) begin
            n_fail++;
            $display("FAIL midframe_reset: got %h expected %h", obs, rst_vec);
        end
        RST = 1'b0;
        drive(10'd799, 1'b0);
        n_checks++;
        if (obs !== rst_vec) begin
            n_fail++;
            $display("FAIL midframe_after: got %h expected %h", obs, rst_vec);
        end
        drive(10'd0, 1'b1);
        n_checks++;
        if (obs !== first_vec) begin
            n_fail++;
            $display("FAIL midframe_restart: got %h expected %h", obs, first_vec);
        end
        RST = 1'b1;
        drive(10'd0, 1'b1);
        n_checks++;
        if (obs !== rst_vec) begin
            n_fail++;
            $display("FAIL rst_with_htc: got %h expected %h", obs, rst_vec);
        end
        RST = 1'b0;
        drive(10'd5, 1'b0);
        exp_v = {1'b1, 1'b1, 1'b0, 10'd0, 9'd0, 10'd524, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL rst_wins_v_held: got %h expected %h", obs, exp_v);
        end
        drive(10'd0, 1'b1);
        n_checks++;
        if (obs !== first_vec) begin
            n_fail++;
            $display("FAIL rst_wins_restart: got %h expected %h", obs, first_vec);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        RST       = 1'b1;
        HADDR     = 10'd0;
        HTC       = 1'b0;
        rst_vec   = {1'b1, 1'b1, 1'b0, 10'd0, 9'd0, 10'd524, 1'b0, 1'b0};
        first_vec = {1'b1, 1'b1, 1'b1, 10'd0, 9'd0, 10'd0, 1'b1, 1'b1};
        #2;
        test_reset();
        test_first_pixel();
        test_hsync();
        test_vsync();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
